// File: rtl/char_console_writer_pkg.sv
// char_console_pkg: shared state enum, control codes and address width for the character console writer.
package char_console_pkg;
  localparam int ADDR_W = 14;
  localparam logic [7:0] CODE_CR = 8'h0D;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] DEFAULT_BLANK_CODE = 8'h20;
  typedef enum logic [1:0] {IDLE, CLR_SCREEN, CLR_LINE} state_t;
endpackage

// File: rtl/char_console_writer_if.sv
// char_console_writer_if: byte stream valid/ready handshake into the console writer.
interface char_console_writer_if;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  modport master (output in_valid, in_data, input in_ready);
  modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/char_addr_calc.sv
// char_addr_calc: registered row*COLS+col character RAM address, loaded only on writes.
module char_addr_calc
  import char_console_pkg::*;
#(
  parameter int COLS = 80
) (
  input  logic              char_write_clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [6:0]        row,
  input  logic [6:0]        col,
  output logic [ADDR_W-1:0] addr
);
  always_ff @(posedge char_write_clock)
    if (!reset_n) addr <= '0;
    else if (load) addr <= ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
endmodule

// File: rtl/char_console_writer.sv
// char_console_writer: byte stream to character RAM writes with cursor tracking and hardware clears.
// Define CHAR_CONSOLE_LINE_CLEAR_EN to blank every new row on newline.
module char_console_writer
  import char_console_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 60,
  parameter logic [7:0] BLANK_CODE = DEFAULT_BLANK_CODE
) (
  input  logic                 char_write_clock,
  input  logic                 reset_n,
  char_console_writer_if.slave stream,
  output logic [ADDR_W-1:0]    char_write_addr,
  output logic [7:0]           char_write_data,
  output logic                 char_write_enable,
  output logic [6:0]           cursor_col,
  output logic [6:0]           cursor_row,
  output logic                 busy
);
`ifdef CHAR_CONSOLE_LINE_CLEAR_EN
  localparam state_t NL_STATE = CLR_LINE;
`else
  localparam state_t NL_STATE = IDLE;
`endif
  state_t state, state_next;
  logic [6:0] col_next, row_next, sweep_col, sweep_row, sweep_col_next, sweep_row_next;
  logic [6:0] wr_row, wr_col, nl_row;
  logic [7:0] wr_data;
  logic sweep_last, sweep_last_next, wr, accept, col_end, sweep_col_end, sweep_row_end;
  assign stream.in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = stream.in_valid && state == IDLE;
  assign col_end = 8'(cursor_col) + 8'd1 == 8'(COLS);
  assign sweep_col_end = 8'(sweep_col) + 8'd1 == 8'(COLS);
  assign sweep_row_end = 8'(sweep_row) + 8'd1 == 8'(ROWS);
  assign nl_row = (8'(cursor_row) + 8'd1 == 8'(ROWS)) ? '0 : cursor_row + 7'd1;
  // Sweeps spend one extra cycle after the last write so in_ready rises after the final strobe.
  always_comb begin
    state_next = state;
    col_next = cursor_col;
    row_next = cursor_row;
    sweep_col_next = sweep_col_end ? '0 : sweep_col + 7'd1;
    sweep_row_next = sweep_row;
    sweep_last_next = sweep_last;
    wr = 1'b0;
    wr_row = cursor_row;
    wr_col = sweep_col;
    wr_data = BLANK_CODE;
    case (state)
      IDLE: begin
        sweep_col_next = '0;
        sweep_row_next = '0;
        sweep_last_next = 1'b0;
        wr_col = cursor_col;
        if (accept) begin
          if (stream.in_data >= 8'h20 && stream.in_data <= 8'h7E) begin
            wr = 1'b1;
            wr_data = stream.in_data;
            col_next = col_end ? '0 : cursor_col + 7'd1;
            row_next = col_end ? nl_row : cursor_row;
            state_next = col_end ? NL_STATE : IDLE;
          end else if (stream.in_data == CODE_CR) begin
            col_next = '0;
          end else if (stream.in_data == CODE_LF) begin
            row_next = nl_row;
            state_next = NL_STATE;
          end else if (stream.in_data == CODE_BS && cursor_col != '0) begin
            col_next = cursor_col - 7'd1;
            wr = 1'b1;
            wr_col = cursor_col - 7'd1;
          end else if (stream.in_data == CODE_FF) begin
            col_next = '0;
            row_next = '0;
            state_next = CLR_SCREEN;
          end
        end
      end
      CLR_SCREEN: begin
        wr = !sweep_last;
        wr_row = sweep_row;
        sweep_row_next = sweep_col_end ? (sweep_row_end ? '0 : sweep_row + 7'd1) : sweep_row;
        sweep_last_next = sweep_col_end && sweep_row_end;
        state_next = sweep_last ? IDLE : CLR_SCREEN;
      end
`ifdef CHAR_CONSOLE_LINE_CLEAR_EN
      CLR_LINE: begin
        wr = !sweep_last;
        sweep_last_next = sweep_col_end;
        state_next = sweep_last ? IDLE : CLR_LINE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge char_write_clock)
    if (!reset_n) begin
      state <= CLR_SCREEN;
      cursor_col <= '0;
      cursor_row <= '0;
      sweep_col <= '0;
      sweep_row <= '0;
      sweep_last <= 1'b0;
      char_write_enable <= 1'b0;
      char_write_data <= '0;
    end else begin
      state <= state_next;
      cursor_col <= col_next;
      cursor_row <= row_next;
      sweep_col <= sweep_col_next;
      sweep_row <= sweep_row_next;
      sweep_last <= sweep_last_next;
      char_write_enable <= wr;
      if (wr) char_write_data <= wr_data;
    end
  char_addr_calc #(.COLS(COLS)) u_addr (
    .char_write_clock(char_write_clock),
    .reset_n(reset_n),
    .load(wr),
    .row(wr_row),
    .col(wr_col),
    .addr(char_write_addr)
  );
endmodule
